// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_ctrl (+ fulladder cell)
// Brief   : Bit-serial adder, LSB first, through a single full-adder cell.
// Revision: 1.0  initial release
// ============================================================================

module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_sum;
  logic fa_carry;

  fulladder u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Result fills from the MSB so the first (LSB) sum bit lands at bit 0
        // after WIDTH shifts.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_q + C_ONE;
        if (cnt_q == C_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign sum_out = res_q;
  assign cout    = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_adder_ctrl
// Brief   : Directed and random self-checking bench, WIDTH=8 and WIDTH=4.
// Revision: 1.0  initial release
// ============================================================================

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a8, b8;
  logic       c8;
  logic [3:0] a4, b4;
  logic       c4;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .a_in(a8), .b_in(b8), .cin(c8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .a_in(a4), .b_in(b4), .cin(c4),
    .busy(busy4), .done(done4), .sum_out(sum4), .cout(cout4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the falling edge just after the accepting edge.
  task automatic launch(input logic [7:0] ia8, input logic [7:0] ib8, input logic ic8,
                        input logic [3:0] ia4, input logic [3:0] ib4, input logic ic4);
    @(negedge clk);
    start = 1'b1;
    a8 = ia8; b8 = ib8; c8 = ic8;
    a4 = ia4; b4 = ib4; c4 = ic4;
    @(negedge clk);
    start = 1'b0;
  endtask

  // edges counts rising edges including the accepting one; -1 on timeout.
  task automatic wait_done(output int edges, output int busy_cnt, output int lat4);
    edges = 1; busy_cnt = 0; lat4 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy8) busy_cnt++;
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done4 && lat4 == 0) lat4 = edges;
      if (done8) return;
    end
    edges = -1;
  endtask

  initial begin
    int         edges, bcnt, lat4;
    logic       saw_done;
    logic [8:0] e8;
    logic [4:0] e4;
    logic [31:0] r;

    rst = 1'b1; start = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
    #12;
    check("reset_outputs", {busy8, done8, cout8, sum8, busy4, done4, cout4, sum4}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy8, done8}, 64'd0);

    // 3C + 0F
    launch(8'h3C, 8'h0F, 1'b0, 4'h3, 4'h5, 1'b0);
    check("busy_after_accept", busy8, 1);
    wait_done(edges, bcnt, lat4);
    check("latency8", edges, 9);
    check("busy_cycles8", bcnt, 8);
    check("sum_3C_0F", {cout8, sum8}, 9'h04B);
    check("latency4", lat4, 5);
    check("sum4_3_5", {cout4, sum4}, 5'h08);
    @(negedge clk);
    check("done_single_pulse", {done8, busy8}, 0);
    check("sum_held_idle", {cout8, sum8}, 9'h04B);

    // overflow cases
    launch(8'hFF, 8'h01, 1'b0, 4'hF, 4'h1, 1'b0);
    wait_done(edges, bcnt, lat4);
    check("sum_FF_01", {cout8, sum8}, 9'h100);
    check("sum4_F_1", {cout4, sum4}, 5'h10);
    launch(8'hA5, 8'h5A, 1'b1, 4'hA, 4'h5, 1'b1);
    wait_done(edges, bcnt, lat4);
    check("sum_A5_5A_c1", {cout8, sum8}, 9'h100);
    check("sum4_A_5_c1", {cout4, sum4}, 5'h10);

    // zeros, pulse width
    launch(8'h00, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0);
    wait_done(edges, bcnt, lat4);
    check("sum_00_00", {cout8, sum8}, 9'h000);
    check("latency_zero_ops", edges, 9);
    @(negedge clk);
    check("done_pulse_zero", done8, 0);

    // start held high, operands change during SHIFT
    @(negedge clk);
    start = 1'b1; a8 = 8'h3C; b8 = 8'h0F; c8 = 1'b0;
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; c8 = 1'b1;
    check("held_start_busy", busy8, 1);
    wait_done(edges, bcnt, lat4);
    check("held_captured_sum", {cout8, sum8}, 9'h04B);
    check("held_busy_cycles", bcnt, 8);
    check("held_done_not_busy", busy8, 0);
    @(negedge clk);
    check("held_idle_cycle", {busy8, done8}, 0);
    @(negedge clk);
    check("held_relaunch", busy8, 1);
    start = 1'b0;
    wait_done(edges, bcnt, lat4);
    check("held_second_sum", {cout8, sum8}, 9'h034);
    check("held_second_latency", edges, 9);

    // async reset in the 4th SHIFT cycle
    launch(8'h3C, 8'h0F, 1'b0, 4'h3, 4'h5, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {busy8, done8, cout8, sum8}, 64'd0);
    #1 rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw_done = saw_done | done8 | busy8;
    end
    check("abort_no_done", saw_done, 0);
    launch(8'h12, 8'h34, 1'b0, 4'h1, 4'h2, 1'b0);
    wait_done(edges, bcnt, lat4);
    check("after_reset_sum", {cout8, sum8}, 9'h046);
    check("after_reset_latency", edges, 9);

    // random sweep, both widths in parallel
    for (int i = 0; i < 500; i++) begin
      r = $urandom;
      e8 = {1'b0, r[7:0]} + {1'b0, r[15:8]} + {8'd0, r[16]};
      e4 = {1'b0, r[20:17]} + {1'b0, r[24:21]} + {4'd0, r[25]};
      launch(r[7:0], r[15:8], r[16], r[20:17], r[24:21], r[25]);
      wait_done(edges, bcnt, lat4);
      check($sformatf("rand8_%0d", i), {cout8, sum8}, e8);
      check($sformatf("rand4_%0d", i), {cout4, sum4}, e4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand bit width; legal range is 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition, sampled only in IDLE.
REQ-005 The block SHALL have port a_in, input, WIDTH bits: operand A, captured when start is accepted.
REQ-006 The block SHALL have port b_in, input, WIDTH bits: operand B, captured when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress (SHIFT state).
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum_out, output, WIDTH bits: registered sum.
REQ-011 The block SHALL have port cout, output, 1 bit: registered final carry-out.

Function
REQ-012 The block SHALL compute {cout, sum_out} = a_in + b_in + cin bit-serially through exactly one instance of the team's fulladder cell (ports a, b, c, sum, carry), LSB first.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE, with IDLE as the reset state.
REQ-014 In IDLE, start=1 at a rising edge SHALL load A/B shift registers, load the carry register with cin, clear the bit counter and enter SHIFT; start=0 SHALL keep the FSM in IDLE.
REQ-015 Each SHIFT edge SHALL feed A[0], B[0] and the carry register to the fulladder, shift A and B right by one, shift the fulladder sum into the result register MSB (shifting the result right), store the fulladder carry and increment the counter.
REQ-016 After the WIDTH-th SHIFT edge the FSM SHALL enter DONE, with sum_out equal to the full WIDTH-bit sum and cout equal to the final carry.
REQ-017 DONE SHALL last exactly one cycle with done=1 and SHALL return unconditionally to IDLE.
REQ-018 Latency SHALL be fixed: done is high in the cycle following WIDTH+1 rising edges after the accepting edge, independent of operand values.
REQ-019 busy SHALL be 1 exactly in SHIFT, and done SHALL be 1 exactly in DONE; both SHALL be decoded from registered state.
REQ-020 start SHALL be ignored in SHIFT and DONE, and operand or cin changes after acceptance SHALL have no effect on the result.
REQ-021 sum_out and cout SHALL hold their last result through IDLE until the next accepted start, and MAY change during SHIFT as partial results shift in.
REQ-022 A start in IDLE in the cycle immediately after done SHALL be accepted (back-to-back operation).
REQ-023 The counter SHALL be $clog2(WIDTH+1) bits wide, and overflow of the sum SHALL appear only on cout with no wrap indication.

Reset
REQ-024 While rst=1, regardless of clk, the state SHALL be IDLE and busy, done, cout, sum_out, the carry register, the counter and the shift registers SHALL all be 0.
REQ-025 rst asserted mid-SHIFT SHALL abort the operation without a done pulse, and the first start after rst deasserts SHALL begin a fresh addition.

Verification
REQ-026 WIDTH=8, a=8'h3C, b=8'h0F, cin=0, start for one cycle -> done after 9 edges, sum_out=8'h4B, cout=0; busy high for exactly 8 cycles.
REQ-027 WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> sum_out=8'h00, cout=1, and a=8'hA5, b=8'h5A, cin=1 -> sum_out=8'h00, cout=1.
REQ-028 WIDTH=8, a=8'h00, b=8'h00, cin=0 -> sum_out=8'h00, cout=0, and done is a single-cycle pulse.
REQ-029 Start held high and a_in/b_in changed during SHIFT -> the result matches the operands captured at acceptance, no second operation starts until IDLE, and the held start then launches the next addition immediately.
REQ-030 rst pulsed (asynchronously, between clock edges) at the 4th SHIFT cycle -> all outputs 0 immediately with no done; then a=8'h12, b=8'h34, cin=0 -> sum_out=8'h46, cout=0.
REQ-031 Exhaustive or random compare over 1000 operand/cin sets against a+b+cin at WIDTH=4 and WIDTH=8 -> zero mismatches.
